// File: rtl/ifu_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch unit, producer side of the IF/ID boundary.
//               Owns the PC, issues sequential word requests on a
//               req/gnt/rvalid bus and buffers returned words in a small
//               prefetch FIFO. Presents {inst, inst_addr, valid} downstream,
//               stalls on hold and redirects/flushes on jump.
// Ports       : clk, rst            clock / async active-high reset
//               jump_en_i/addr_i    redirect request and target
//               hold_flag_i         downstream stall (no pop)
//               mem_req_o/addr_o    fetch request and address (= PC)
//               mem_gnt_i           request accepted
//               mem_rvalid_i/rdata  in-order response word
//               inst_o/addr_o       FIFO head (NOP / 0 when empty)
//               inst_valid_o        FIFO non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int unsigned    c_PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned    c_CW        = c_PW + 1;
  localparam logic [31:0]    c_NOP       = 32'h0000_0013;
  localparam logic [c_PW-1:0] c_PTR_ONE  = 1;
  localparam logic [c_CW-1:0] c_CNT_ONE  = 1;
  localparam logic [c_CW:0]  c_DEPTH     = FIFO_DEPTH;

  localparam logic [1:0] c_ST_BOOT  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [c_CW-1:0] inflight_q, inflight_d;
  logic [c_CW-1:0] count_q, count_d;
  logic [c_CW-1:0] stale_q, stale_d;
  logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PW-1:0] tag_wr_q, tag_wr_d;
  logic [c_PW-1:0] tag_rd_q, tag_rd_d;
  logic [31:0]     fifo_inst_q [FIFO_DEPTH];
  logic [31:0]     fifo_inst_d [FIFO_DEPTH];
  logic [31:0]     fifo_addr_q [FIFO_DEPTH];
  logic [31:0]     fifo_addr_d [FIFO_DEPTH];
  // Address of every outstanding request, in issue order; consumed one per
  // response so stale responses after a redirect keep the ring aligned.
  logic [31:0]     tag_q [FIFO_DEPTH];
  logic [31:0]     tag_d [FIFO_DEPTH];

  logic w_issue;
  logic w_rv;
  logic w_push;
  logic w_pop;

  // Credit check on registered counts only: every outstanding request has a
  // guaranteed FIFO slot, so the FIFO can never overflow.
  assign mem_req_o    = (state_q == c_ST_RUN) &&
                        (({1'b0, inflight_q} + {1'b0, count_q}) < c_DEPTH);
  assign mem_addr_o   = pc_q;
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? fifo_inst_q[rd_ptr_q] : c_NOP;
  assign inst_addr_o  = inst_valid_o ? fifo_addr_q[rd_ptr_q] : 32'h0;

  assign w_issue = mem_req_o && mem_gnt_i;
  // A response with nothing outstanding is a bus error and is ignored.
  assign w_rv    = mem_rvalid_i && (inflight_q != '0);
  assign w_push  = w_rv && (stale_q == '0) && !jump_en_i;
  assign w_pop   = inst_valid_o && !hold_flag_i && !jump_en_i;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inflight_d  = inflight_q;
    count_d     = count_q;
    stale_d     = stale_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    tag_wr_d    = tag_wr_q;
    tag_rd_d    = tag_rd_q;
    fifo_inst_d = fifo_inst_q;
    fifo_addr_d = fifo_addr_q;
    tag_d       = tag_q;

    // Bus bookkeeping runs regardless of jump: an accepted request or a
    // returned word is real traffic even when it is about to be discarded.
    if (w_issue) begin
      tag_d[tag_wr_q] = pc_q;
      tag_wr_d        = tag_wr_q + c_PTR_ONE;
      inflight_d      = inflight_d + c_CNT_ONE;
    end
    if (w_rv) begin
      tag_rd_d   = tag_rd_q + c_PTR_ONE;
      inflight_d = inflight_d - c_CNT_ONE;
    end

    if (jump_en_i) begin
      // Everything still on the bus after this edge belongs to the old path.
      pc_d     = jump_addr_i;
      stale_d  = inflight_d;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      state_d  = (inflight_d != '0) ? c_ST_DRAIN : c_ST_RUN;
    end else begin
      case (state_q)
        c_ST_BOOT: state_d = c_ST_RUN;
        c_ST_RUN: begin
          if (w_issue) begin
            pc_d = pc_q + 32'd4;
          end
        end
        c_ST_DRAIN: begin
          if (w_rv) begin
            stale_d = stale_q - c_CNT_ONE;
            if (stale_q == c_CNT_ONE) begin
              state_d = c_ST_RUN;
            end
          end
        end
        default: state_d = c_ST_BOOT;
      endcase

      if (w_push) begin
        fifo_inst_d[wr_ptr_q] = mem_rdata_i;
        fifo_addr_d[wr_ptr_q] = tag_q[tag_rd_q];
        wr_ptr_d              = wr_ptr_q + c_PTR_ONE;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        count_d = count_q + c_CNT_ONE;
      end else if (w_pop && !w_push) begin
        count_d = count_q - c_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= c_ST_BOOT;
      pc_q       <= RESET_ADDR;
      inflight_q <= '0;
      count_q    <= '0;
      stale_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_inst_q[i] <= '0;
        fifo_addr_q[i] <= '0;
        tag_q[i]       <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      stale_q     <= stale_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_addr_q <= fifo_addr_d;
      tag_q       <= tag_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Self-checking bench for ifu_fetch. A queue-based model of the
//               prefetch buffer and outstanding bus traffic predicts every
//               output each cycle; a second instance with a wrapping reset
//               address is checked against a fixed vector table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RA2   = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        hold_flag_i = 1'b0;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  logic        gnt2 = 1'b0;
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        req2;
  logic [31:0] addr2;
  logic [31:0] inst2;
  logic [31:0] iaddr2;
  logic        valid2;

  ifu_fetch #(.RESET_ADDR(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .hold_flag_i(hold_flag_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
  );

  ifu_fetch #(.RESET_ADDR(RA2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst),
    .jump_en_i(1'b0), .jump_addr_i(32'h0), .hold_flag_i(1'b0),
    .mem_req_o(req2), .mem_addr_o(addr2), .mem_gnt_i(gnt2),
    .mem_rvalid_i(rvalid2), .mem_rdata_i(rdata2),
    .inst_o(inst2), .inst_addr_o(iaddr2), .inst_valid_o(valid2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; logic [31:0] data; } word_t;
  typedef struct { logic [31:0] addr; bit stale; } req_t;

  word_t       fifo_m[$];   // words delivered, not yet consumed downstream
  req_t        pend_m[$];   // requests accepted, response not yet seen
  logic [31:0] mem_q[$];    // bus-side view: addresses awaiting a response
  logic [31:0] pc_m;
  bit          boot_m;
  logic [31:0] dxor;

  task automatic model_reset();
    fifo_m.delete();
    pend_m.delete();
    mem_q.delete();
    pc_m   = 32'h0;
    boot_m = 1'b1;
  endtask

  function automatic bit exp_req();
    bit any_stale = 1'b0;
    for (int i = 0; i < pend_m.size(); i++) if (pend_m[i].stale) any_stale = 1'b1;
    return !boot_m && !any_stale && ((pend_m.size() + fifo_m.size()) < DEPTH);
  endfunction

  task automatic model_step(input bit j, input logic [31:0] ja, input bit h,
                            input bit iss, input bit rv, input logic [31:0] rd);
    req_t  r;
    word_t w;
    bit    do_pop;
    do_pop = (fifo_m.size() > 0) && !h && !j;
    if (rv && pend_m.size() > 0) begin
      r = pend_m.pop_front();
      if (!r.stale && !j) begin
        w.addr = r.addr;
        w.data = rd;
        fifo_m.push_back(w);
      end
    end
    if (do_pop) w = fifo_m.pop_front();
    if (j) begin
      fifo_m.delete();
      for (int i = 0; i < pend_m.size(); i++) pend_m[i].stale = 1'b1;
      if (iss) begin
        r.addr = pc_m; r.stale = 1'b1;
        pend_m.push_back(r);
      end
      pc_m = ja;
    end else if (iss) begin
      r.addr = pc_m; r.stale = 1'b0;
      pend_m.push_back(r);
      pc_m = pc_m + 32'd4;
    end
    boot_m = 1'b0;
  endtask

  task automatic check_outputs();
    bit          v;
    logic [31:0] ea;
    logic [31:0] ei;
    v  = fifo_m.size() > 0;
    ea = v ? fifo_m[0].addr : 32'h0;
    ei = v ? fifo_m[0].data : NOP;
    chk32("mem_req",   {31'b0, mem_req_o},    {31'b0, exp_req()});
    chk32("mem_addr",  mem_addr_o,            pc_m);
    chk32("inst_valid",{31'b0, inst_valid_o}, {31'b0, v});
    chk32("inst_addr", inst_addr_o,           ea);
    chk32("inst",      inst_o,                ei);
  endtask

  // One clock cycle: check, drive, clock, advance model. Entered at posedge+1.
  task automatic do_cycle(input bit j, input logic [31:0] ja, input bit h,
                          input int gp, input int rp, input int errp);
    bit          req_s;
    bit          ereq;
    logic [31:0] addr_s;
    logic [31:0] dummy;
    check_outputs();
    ereq   = exp_req();
    req_s  = mem_req_o;
    addr_s = mem_addr_o;
    jump_en_i   = j;
    jump_addr_i = ja;
    hold_flag_i = h;
    mem_gnt_i   = ($urandom_range(99) < gp);
    if (mem_q.size() > 0) begin
      mem_rvalid_i = ($urandom_range(99) < rp);
      mem_rdata_i  = mem_q[0] ^ dxor;
    end else begin
      mem_rvalid_i = ($urandom_range(99) < errp);
      mem_rdata_i  = $urandom;
    end
    @(posedge clk);
    if (mem_rvalid_i && mem_q.size() > 0) dummy = mem_q.pop_front();
    if (req_s && mem_gnt_i) mem_q.push_back(addr_s);
    model_step(j, ja, h, ereq && mem_gnt_i, mem_rvalid_i, mem_rdata_i);
    #1;
  endtask

  task automatic idle_inputs();
    jump_en_i = 1'b0; jump_addr_i = '0; hold_flag_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_target(input logic [31:0] tgt, input string name);
    int n = 0;
    while (!inst_valid_o && n < 40) begin
      do_cycle(1'b0, 32'h0, 1'b0, 100, 100, 0);
      n++;
    end
    if (!inst_valid_o) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no valid instruction within 40 cycles, expected addr %h", name, tgt);
    end else begin
      chk32(name, inst_addr_o, tgt);
    end
  endtask

  task automatic build_inflight(input int n);
    int b = 0;
    while ((mem_q.size() < n || !mem_req_o) && mem_q.size() < n && b < 30) begin
      do_cycle(1'b0, 32'h0, 1'b0, 100, 0, 0);
      b++;
    end
  endtask

  // ---------------- vector table for the wrapping-reset instance ----------
  typedef struct {
    bit          gnt;
    bit          e_req;
    logic [31:0] e_maddr;
    bit          e_valid;
    logic [31:0] e_iaddr;
  } vec_t;
  vec_t vec [11];

  initial begin
    bit          prev_iss;
    logic [31:0] prev_addr;
    bit          j;
    bit          h;
    logic [31:0] ja;

    vec[0]  = '{1'b1, 1'b0, 32'hFFFF_FFF8, 1'b0, 32'h0};
    vec[1]  = '{1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
    vec[2]  = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vec[3]  = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8};
    vec[4]  = '{1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC};
    vec[5]  = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
    vec[6]  = '{1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004};
    vec[7]  = '{1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008};
    vec[8]  = '{1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};
    vec[9]  = '{1'b1, 1'b1, 32'h0000_0014, 1'b0, 32'h0};
    vec[10] = '{1'b1, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_0010};

    dxor = 32'h0;
    model_reset();
    apply_reset();

    // Streaming with single-cycle memory: addr returned as data.
    repeat (12) do_cycle(1'b0, 32'h0, 1'b0, 100, 100, 0);

    // Downstream stall fills the buffer, then release.
    repeat (10) do_cycle(1'b0, 32'h0, 1'b1, 100, 100, 0);
    chk32("hold_full_req", {31'b0, mem_req_o}, 32'h0);
    repeat (10) do_cycle(1'b0, 32'h0, 1'b0, 100, 100, 0);

    // Redirect with two requests outstanding.
    dxor = 32'h1234_5678;
    build_inflight(2);
    do_cycle(1'b1, 32'h0000_0100, 1'b0, 0, 0, 0);
    wait_target(32'h0000_0100, "jump_target_100");
    repeat (5) do_cycle(1'b0, 32'h0, 1'b0, 100, 100, 0);

    // Redirect coinciding with a grant and a response.
    build_inflight(1);
    do_cycle(1'b1, 32'h0000_0200, 1'b0, 100, 100, 0);
    wait_target(32'h0000_0200, "jump_gnt_rv_200");
    repeat (5) do_cycle(1'b0, 32'h0, 1'b0, 100, 100, 0);

    // Randomised traffic, including bus-error responses and wrapping targets.
    dxor = 32'hDEAD_BEEF;
    for (int i = 0; i < 3000; i++) begin
      j  = ($urandom_range(99) < 3);
      h  = ($urandom_range(99) < 30);
      ja = ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      do_cycle(j, ja, h, 60, 60, 5);
    end

    // Reset asserted mid-drain takes effect without a clock edge.
    idle_inputs();
    repeat (3) do_cycle(1'b0, 32'h0, 1'b0, 100, 100, 0);
    build_inflight(2);
    do_cycle(1'b1, 32'h0000_0300, 1'b0, 0, 0, 0);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk32("rst_mem_req",    {31'b0, mem_req_o},    32'h0);
    chk32("rst_mem_addr",   mem_addr_o,            32'h0);
    chk32("rst_inst_valid", {31'b0, inst_valid_o}, 32'h0);
    chk32("rst_inst",       inst_o,                NOP);
    chk32("rst_inst_addr",  inst_addr_o,           32'h0);
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      j  = ($urandom_range(99) < 3);
      h  = ($urandom_range(99) < 30);
      ja = $urandom & 32'hFFFF_FFFC;
      do_cycle(j, ja, h, 70, 70, 5);
    end

    // Wrapping reset address on the second instance, table driven.
    apply_reset();
    prev_iss  = 1'b0;
    prev_addr = '0;
    for (int k = 0; k < 11; k++) begin
      chk32($sformatf("ra2_req[%0d]", k),   {31'b0, req2},   {31'b0, vec[k].e_req});
      chk32($sformatf("ra2_maddr[%0d]", k), addr2,           vec[k].e_maddr);
      chk32($sformatf("ra2_valid[%0d]", k), {31'b0, valid2}, {31'b0, vec[k].e_valid});
      chk32($sformatf("ra2_iaddr[%0d]", k), iaddr2,          vec[k].e_iaddr);
      chk32($sformatf("ra2_inst[%0d]", k),  inst2,
            vec[k].e_valid ? vec[k].e_iaddr : NOP);
      gnt2    = vec[k].gnt;
      rvalid2 = prev_iss;
      rdata2  = prev_addr;
      prev_iss  = req2 && vec[k].gnt;
      prev_addr = addr2;
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
